// File: rtl/cpu_gen2_if.sv
// Fetch/IO bundle between the cpu_gen2 core (master) and its program
// memory / IO environment (slave).
interface cpu_gen2_if #(
   parameter int WIDTH  = 4,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] fetch_addr;
   logic [WIDTH+3:0]  instr;
   logic              instr_valid;
   logic [WIDTH-1:0]  in;
   logic [WIDTH-1:0]  out;
   logic              out_strobe;
   logic              carry;
   logic              halted;
   logic              fault;

   modport master (
      output fetch_addr, out, out_strobe, carry, halted, fault,
      input  instr, instr_valid, in
   );

   modport slave (
      input  fetch_addr, out, out_strobe, carry, halted, fault,
      output instr, instr_valid, in
   );
endinterface

// File: rtl/cpu_gen2.sv
// Single-cycle 16-opcode accumulator core with a bounded return-address
// stack; stack misuse stops the core with a sticky fault.
module cpu_gen2 #(
   parameter int WIDTH       = 4,
   parameter int ADDR_W      = 4,
   parameter int STACK_DEPTH = 4
) (
   input logic       clock,
   input logic       reset,
   cpu_gen2_if.master bus
);
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   if (ADDR_W < WIDTH) begin : g_bad_addr_w
      $error("cpu_gen2: ADDR_W must be >= WIDTH");
   end
   if (STACK_DEPTH < 1) begin : g_bad_depth
      $error("cpu_gen2: STACK_DEPTH must be >= 1");
   end

   logic [WIDTH-1:0]  a_r, b_r, out_r;
   logic              c_r, strobe_r, halted_r, fault_r;
   logic [ADDR_W-1:0] pc_r;
   logic [SP_W-1:0]   sp_r;
   logic [ADDR_W-1:0] stack_mem_r [STACK_DEPTH];

   logic [WIDTH-1:0]  a_s, b_s, out_s;
   logic              c_s, strobe_s, halted_s, fault_s, push_s, exec_s;
   logic [ADDR_W-1:0] pc_s, pc_inc_s, target_s;
   logic [SP_W-1:0]   sp_s;
   logic [3:0]        opcode_s;
   logic [WIDTH-1:0]  imm_s;
   logic [WIDTH:0]    add_ai_s, add_bi_s, add_ab_s;
   logic [IDX_W-1:0]  push_idx_s, top_idx_s;

   assign opcode_s   = bus.instr[WIDTH+3:WIDTH];
   assign imm_s      = bus.instr[WIDTH-1:0];
   assign exec_s     = reset && bus.instr_valid && !halted_r;
   assign pc_inc_s   = pc_r + ADDR_W'(1'b1);
   assign target_s   = ADDR_W'(imm_s);
   assign add_ai_s   = {1'b0, a_r} + {1'b0, imm_s};
   assign add_bi_s   = {1'b0, b_r} + {1'b0, imm_s};
   assign add_ab_s   = {1'b0, a_r} + {1'b0, b_r};
   assign push_idx_s = IDX_W'(sp_r);
   assign top_idx_s  = IDX_W'(sp_r - SP_W'(1'b1));

   // Next-state decode of the instruction presented this cycle.
   always_comb begin
      a_s      = a_r;
      b_s      = b_r;
      c_s      = c_r;
      pc_s     = pc_r;
      sp_s     = sp_r;
      out_s    = out_r;
      strobe_s = 1'b0;
      halted_s = halted_r;
      fault_s  = fault_r;
      push_s   = 1'b0;
      if (exec_s) begin
         c_s  = 1'b0;
         pc_s = pc_inc_s;
         case (opcode_s)
            4'h0: {c_s, a_s} = add_ai_s;
            4'h1: a_s = b_r;
            4'h2: a_s = bus.in;
            4'h3: a_s = imm_s;
            4'h4: b_s = a_r;
            4'h5: {c_s, b_s} = add_bi_s;
            4'h6: b_s = bus.in;
            4'h7: b_s = imm_s;
            4'h8: begin
               if (sp_r < SP_W'(STACK_DEPTH)) begin
                  push_s = 1'b1;
                  sp_s   = sp_r + SP_W'(1'b1);
                  pc_s   = target_s;
               end else begin
                  pc_s     = pc_r;
                  fault_s  = 1'b1;
                  halted_s = 1'b1;
               end
            end
            4'h9: begin
               out_s    = b_r;
               strobe_s = 1'b1;
            end
            4'hA: begin
               if (sp_r != {SP_W{1'b0}}) begin
                  sp_s = sp_r - SP_W'(1'b1);
                  pc_s = stack_mem_r[top_idx_s];
               end else begin
                  pc_s     = pc_r;
                  fault_s  = 1'b1;
                  halted_s = 1'b1;
               end
            end
            4'hB: begin
               out_s    = imm_s;
               strobe_s = 1'b1;
            end
            4'hC: begin
               pc_s     = pc_r;
               halted_s = 1'b1;
            end
            4'hD: {c_s, a_s} = add_ab_s;
            4'hE: pc_s = target_s;
            4'hF: pc_s = c_r ? pc_inc_s : target_s;
            default: pc_s = pc_r;
         endcase
      end else begin
         strobe_s = 1'b0;
      end
   end

   // Architectural state; stack entries are deliberately left unreset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         c_r      <= 1'b0;
         pc_r     <= {ADDR_W{1'b0}};
         sp_r     <= {SP_W{1'b0}};
         out_r    <= {WIDTH{1'b0}};
         strobe_r <= 1'b0;
         halted_r <= 1'b0;
         fault_r  <= 1'b0;
      end else begin
         a_r      <= a_s;
         b_r      <= b_s;
         c_r      <= c_s;
         pc_r     <= pc_s;
         sp_r     <= sp_s;
         out_r    <= out_s;
         strobe_r <= strobe_s;
         halted_r <= halted_s;
         fault_r  <= fault_s;
      end
   end

   // Return-address storage.
   always_ff @(posedge clock) begin
      if (push_s) begin
         stack_mem_r[push_idx_s] <= pc_inc_s;
      end
   end

   assign bus.fetch_addr = pc_r;
   assign bus.out        = out_r;
   assign bus.out_strobe = strobe_r;
   assign bus.carry      = c_r;
   assign bus.halted     = halted_r;
   assign bus.fault      = fault_r;
endmodule

// File: tb/tb_cpu_gen2.sv
// Directed-vector bench for cpu_gen2 at default parameters.
module tb_cpu_gen2;
   logic clock;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   cpu_gen2_if #(.WIDTH(4), .ADDR_W(4)) bus_if ();

   cpu_gen2 #(.WIDTH(4), .ADDR_W(4), .STACK_DEPTH(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic exec(input logic [3:0] op, input logic [3:0] imm);
      @(negedge clock);
      bus_if.instr       = {op, imm};
      bus_if.instr_valid = 1'b1;
      @(posedge clock);
      #1;
      bus_if.instr_valid = 1'b0;
   endtask

   task automatic idle();
      @(negedge clock);
      bus_if.instr_valid = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pc"},     32'(bus_if.fetch_addr), 32'h0);
      check({tag, "_out"},    32'(bus_if.out),        32'h0);
      check({tag, "_strobe"}, 32'(bus_if.out_strobe), 32'h0);
      check({tag, "_carry"},  32'(bus_if.carry),      32'h0);
      check({tag, "_halted"}, 32'(bus_if.halted),     32'h0);
      check({tag, "_fault"},  32'(bus_if.fault),      32'h0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_all_zero("reset");
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      reset              = 1'b0;
      bus_if.instr       = 8'h00;
      bus_if.instr_valid = 1'b0;
      bus_if.in          = 4'h0;
      #2;
      check_all_zero("por");
      @(negedge clock);
      reset = 1'b1;

      // MOV A,5 ; ADD A,12 ; JNC 7 -> A=1, C=1, no jump
      exec(4'h3, 4'h5);
      check("mov_pc", 32'(bus_if.fetch_addr), 32'h1);
      exec(4'h0, 4'hC);
      check("add_carry", 32'(bus_if.carry), 32'h1);
      check("add_pc", 32'(bus_if.fetch_addr), 32'h2);
      exec(4'hF, 4'h7);
      check("jnc_taken_not", 32'(bus_if.fetch_addr), 32'h3);
      check("jnc_clear_c", 32'(bus_if.carry), 32'h0);
      exec(4'h4, 4'h0);
      exec(4'h9, 4'h0);
      check("outb_a", 32'(bus_if.out), 32'h1);
      check("outb_strobe", 32'(bus_if.out_strobe), 32'h1);
      check("outb_pc", 32'(bus_if.fetch_addr), 32'h5);

      // stall then OUT imm 9
      for (int i = 0; i < 3; i++) begin
         idle();
         check("stall_pc", 32'(bus_if.fetch_addr), 32'h5);
         check("stall_out", 32'(bus_if.out), 32'h1);
         check("stall_strobe", 32'(bus_if.out_strobe), 32'h0);
      end
      exec(4'hB, 4'h9);
      check("outi_out", 32'(bus_if.out), 32'h9);
      check("outi_strobe", 32'(bus_if.out_strobe), 32'h1);
      check("outi_pc", 32'(bus_if.fetch_addr), 32'h6);
      idle();
      check("outi_strobe_drop", 32'(bus_if.out_strobe), 32'h0);
      check("outi_hold", 32'(bus_if.out), 32'h9);

      // JNC taken with C=0
      exec(4'hF, 4'hA);
      check("jnc_taken", 32'(bus_if.fetch_addr), 32'hA);

      // ADD B,imm wrap to zero with carry
      exec(4'h7, 4'hF);
      exec(4'h5, 4'h1);
      check("addb_carry", 32'(bus_if.carry), 32'h1);
      check("addb_pc", 32'(bus_if.fetch_addr), 32'hC);
      exec(4'h9, 4'h0);
      check("addb_result", 32'(bus_if.out), 32'h0);
      check("outb_clear_c", 32'(bus_if.carry), 32'h0);

      // IN A ; ADD A,B (B=0) ; MOV B,A with PC wrap ; OUT B
      bus_if.in = 4'h6;
      exec(4'h2, 4'h0);
      exec(4'hD, 4'h0);
      check("addab_carry", 32'(bus_if.carry), 32'h0);
      check("addab_pc", 32'(bus_if.fetch_addr), 32'hF);
      exec(4'h4, 4'h0);
      check("pc_wrap", 32'(bus_if.fetch_addr), 32'h0);
      exec(4'h9, 4'h0);
      check("in_a_out", 32'(bus_if.out), 32'h6);

      // IN B ; MOV A,B ; ADD A,3 -> 0x11 ; MOV B,A ; OUT B
      bus_if.in = 4'hE;
      exec(4'h6, 4'h0);
      exec(4'h1, 4'h0);
      exec(4'h0, 4'h3);
      check("adda_ovf_carry", 32'(bus_if.carry), 32'h1);
      exec(4'h4, 4'h0);
      exec(4'h9, 4'h0);
      check("adda_ovf_out", 32'(bus_if.out), 32'h1);
      check("seq_pc", 32'(bus_if.fetch_addr), 32'h6);

      // JMP 0 then nested CALLs to full depth and RETs
      exec(4'hE, 4'h0);
      check("jmp_pc", 32'(bus_if.fetch_addr), 32'h0);
      exec(4'h8, 4'h4);
      check("call1", 32'(bus_if.fetch_addr), 32'h4);
      exec(4'h8, 4'h8);
      check("call2", 32'(bus_if.fetch_addr), 32'h8);
      exec(4'h8, 4'hC);
      check("call3", 32'(bus_if.fetch_addr), 32'hC);
      exec(4'h8, 4'h2);
      check("call4", 32'(bus_if.fetch_addr), 32'h2);
      exec(4'hA, 4'h0);
      check("ret4", 32'(bus_if.fetch_addr), 32'hD);
      exec(4'hA, 4'h0);
      check("ret3", 32'(bus_if.fetch_addr), 32'h9);
      exec(4'hA, 4'h0);
      check("ret2", 32'(bus_if.fetch_addr), 32'h5);
      exec(4'hA, 4'h0);
      check("ret1", 32'(bus_if.fetch_addr), 32'h1);
      check("ret_fault", 32'(bus_if.fault), 32'h0);

      // fill the stack, then overflow
      exec(4'hB, 4'hA);
      exec(4'hE, 4'h0);
      exec(4'h8, 4'h4);
      exec(4'h8, 4'h8);
      exec(4'h8, 4'hC);
      exec(4'h8, 4'h2);
      exec(4'h8, 4'h6);
      check("ovf_fault", 32'(bus_if.fault), 32'h1);
      check("ovf_halted", 32'(bus_if.halted), 32'h1);
      check("ovf_pc", 32'(bus_if.fetch_addr), 32'h2);
      exec(4'hB, 4'h5);
      check("halted_out_hold", 32'(bus_if.out), 32'hA);
      check("halted_no_strobe", 32'(bus_if.out_strobe), 32'h0);
      check("halted_pc_hold", 32'(bus_if.fetch_addr), 32'h2);

      // asynchronous reset between edges while halted
      #3;
      reset = 1'b0;
      #1;
      check_all_zero("async");
      @(negedge clock);
      reset = 1'b1;

      // RET on empty stack as first instruction
      exec(4'hA, 4'h0);
      check("uflow_fault", 32'(bus_if.fault), 32'h1);
      check("uflow_halted", 32'(bus_if.halted), 32'h1);
      check("uflow_pc", 32'(bus_if.fetch_addr), 32'h0);
      exec(4'hE, 4'h7);
      check("uflow_pc_hold", 32'(bus_if.fetch_addr), 32'h0);
      check("uflow_fault_hold", 32'(bus_if.fault), 32'h1);

      // HALT clears C and parks PC on itself
      do_reset();
      exec(4'h3, 4'hF);
      exec(4'h0, 4'h1);
      check("pre_halt_carry", 32'(bus_if.carry), 32'h1);
      exec(4'hC, 4'h0);
      check("halt_halted", 32'(bus_if.halted), 32'h1);
      check("halt_carry", 32'(bus_if.carry), 32'h0);
      check("halt_pc", 32'(bus_if.fetch_addr), 32'h2);
      check("halt_fault", 32'(bus_if.fault), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
